// File: rtl/card_dealer_rng.sv
`default_nettype none
// ============================================================================
// Module   : card_dealer_rng
// Brief    : LFSR-driven card source with per-rank shoe accounting and a
//            request/valid handshake; falls back to a linear scan after
//            MAX_TRIES rejected random draws.
// Revision : 1.0
// ============================================================================
module card_dealer_rng #(
  parameter int unsigned       LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] TAPS      = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
  parameter int unsigned       DECKS     = 1,
  parameter int unsigned       MAX_TRIES = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          reseed,
  input  logic [LFSR_W-1:0]             seed_in,
  input  logic                          shuffle,
  input  logic                          req,
  output logic                          busy,
  output logic                          card_valid,
  output logic [3:0]                    card_rank,
  output logic                          empty_err,
  output logic [$clog2(52*DECKS+1)-1:0] cards_left
);

  localparam int unsigned c_cnt_w  = $clog2(4*DECKS+1);
  localparam int unsigned c_left_w = $clog2(52*DECKS+1);
  localparam int unsigned c_try_w  = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  localparam logic [c_cnt_w-1:0]  c_full_cnt  = c_cnt_w'(4*DECKS);
  localparam logic [c_left_w-1:0] c_full_left = c_left_w'(52*DECKS);
  localparam logic [c_try_w-1:0]  c_last_try  = c_try_w'(MAX_TRIES-1);
  localparam logic [LFSR_W-1:0]   c_seed      = (SEED == '0) ? LFSR_W'(1) : SEED;

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_draw = 2'd1;
  localparam logic [1:0] c_scan = 2'd2;

  logic [LFSR_W-1:0]  r_lfsr;
  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_try_w-1:0] r_tries;
  logic [3:0]         r_ptr;
  logic [c_cnt_w-1:0] r_cnt [1:13];
  logic [3:0]         w_pick;
  logic               w_pick_ok;
  logic [c_cnt_w-1:0] w_pick_cnt;
  logic               w_accept;
  logic               w_last_try;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_lfsr <= c_seed;
    else if (reseed)
      r_lfsr <= (seed_in == '0) ? c_seed : seed_in;
    else if (r_lfsr == '0)
      r_lfsr <= c_seed;
    else
      r_lfsr <= {r_lfsr[LFSR_W-2:0], ^(r_lfsr & TAPS)};
  end

  // DRAW tests the LFSR candidate, SCAN tests the walking pointer.
  assign w_pick     = (r_state == c_scan) ? r_ptr : r_lfsr[3:0];
  assign w_pick_ok  = (w_pick >= 4'd1) && (w_pick <= 4'd13);
  assign w_accept   = (r_state != c_idle) && w_pick_ok && (w_pick_cnt != '0);
  assign w_last_try = (r_tries == c_last_try);

  always_comb begin
    w_pick_cnt = '0;
    for (int i = 1; i <= 13; i++)
      if (w_pick == 4'(i)) w_pick_cnt = r_cnt[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_idle;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (shuffle)
      w_state_nxt = c_idle;
    else begin
      case (r_state)
        c_idle:  if (req && (cards_left != '0)) w_state_nxt = c_draw;
        c_draw: begin
          if (w_accept)        w_state_nxt = c_idle;
          else if (w_last_try) w_state_nxt = c_scan;
        end
        c_scan:  if (w_accept) w_state_nxt = c_idle;
        default: w_state_nxt = c_idle;
      endcase
    end
  end

  always_comb begin
    busy = (r_state == c_draw) || (r_state == c_scan);
  end

  // Shuffle outranks an accept in the same cycle, so an aborted draw never decrements.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= 13; i++) r_cnt[i] <= c_full_cnt;
      cards_left <= c_full_left;
      card_rank  <= '0;
      card_valid <= 1'b0;
      empty_err  <= 1'b0;
      r_tries    <= '0;
      r_ptr      <= 4'd1;
    end else begin
      card_valid <= 1'b0;
      empty_err  <= 1'b0;
      if (shuffle) begin
        for (int i = 1; i <= 13; i++) r_cnt[i] <= c_full_cnt;
        cards_left <= c_full_left;
      end else if (w_accept) begin
        for (int i = 1; i <= 13; i++)
          if (w_pick == 4'(i)) r_cnt[i] <= r_cnt[i] - 1'b1;
        cards_left <= cards_left - 1'b1;
        card_rank  <= w_pick;
        card_valid <= 1'b1;
      end else begin
        case (r_state)
          c_idle: begin
            if (req) begin
              if (cards_left == '0) empty_err <= 1'b1;
              r_tries <= '0;
            end
          end
          c_draw: begin
            if (w_last_try) r_ptr <= w_pick_ok ? w_pick : 4'd1;
            else            r_tries <= r_tries + 1'b1;
          end
          c_scan:  r_ptr <= (r_ptr == 4'd13) ? 4'd1 : r_ptr + 4'd1;
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_card_dealer_rng.sv
`default_nettype none
// ============================================================================
// Module   : tb_card_dealer_rng
// Brief    : Randomized self-checking bench against a card-level shoe model.
// Revision : 1.0
// ============================================================================
module tb_card_dealer_rng;

  localparam int          MT   = 2;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] TAPS = 16'hB400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reseed = 1'b0;
  logic [15:0] seed_in = '0;
  logic        shuffle = 1'b0;
  logic        req = 1'b0;
  logic        busy, card_valid, empty_err;
  logic [3:0]  card_rank;
  logic [5:0]  cards_left;

  int          n_vec = 0;
  int          n_err = 0;
  int          shoe [1:13];
  int          left;
  logic [15:0] m_lfsr = SEED;

  card_dealer_rng #(
    .LFSR_W(16), .TAPS(TAPS), .SEED(SEED), .DECKS(1), .MAX_TRIES(MT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .reseed(reseed), .seed_in(seed_in),
    .shuffle(shuffle), .req(req), .busy(busy), .card_valid(card_valid),
    .card_rank(card_rank), .empty_err(empty_err), .cards_left(cards_left)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] nxt(input logic [15:0] l);
    if (l == 16'd0) return SEED;
    return {l[14:0], 1'($countones(l & TAPS) % 2)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      m_lfsr <= SEED;
    else if (reseed) m_lfsr <= (seed_in == 16'd0) ? SEED : seed_in;
    else             m_lfsr <= nxt(m_lfsr);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic fill_shoe();
    for (int r = 1; r <= 13; r++) shoe[r] = 4;
    left = 52;
  endtask

  // Which rank the next request yields and how many edges after the request edge.
  function automatic void predict(input logic [15:0] l0, output int rank, output int lat);
    logic [15:0] l;
    int c, ptr, p;
    l = l0; c = 0; rank = 0; lat = 1;
    for (int k = 0; k < MT; k++) begin
      l = nxt(l);
      c = int'(l[3:0]);
      if (c >= 1 && c <= 13 && shoe[c] > 0) begin
        rank = c; lat = k + 1; return;
      end
    end
    ptr = (c >= 1 && c <= 13) ? c : 1;
    for (int s = 0; s < 13; s++) begin
      p = ((ptr - 1 + s) % 13) + 1;
      if (shoe[p] > 0) begin
        rank = p; lat = MT + 1 + s; return;
      end
    end
  endfunction

  task automatic do_draw(input int gap, output int got, output int exp_rank);
    int lat;
    repeat (gap) @(negedge clk);
    predict(m_lfsr, exp_rank, lat);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    for (int n = 1; n <= lat; n++) begin
      @(negedge clk);
      if (n < lat) begin
        chk("busy_wait", busy, 1);
        chk("early_valid", card_valid, 0);
      end
    end
    chk("valid", card_valid, 1);
    chk("busy_fall", busy, 0);
    chk("rank", card_rank, exp_rank);
    got = int'(card_rank);
    if (exp_rank >= 1 && exp_rank <= 13) shoe[exp_rank]--;
    left--;
    chk("cards_left", cards_left, left);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          got, er;
    int          cnt [1:13];
    int          exp1 [10];
    int          gaps [10];
    logic [15:0] s;

    fill_shoe();
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", card_valid, 0);
    chk("rst_rank", card_rank, 0);
    chk("rst_empty", empty_err, 0);
    chk("rst_left", cards_left, 52);
    chk("rst_lfsr", dut.r_lfsr, SEED);
    rst_n = 1'b1;

    @(negedge clk);
    reseed = 1'b1; seed_in = 16'd0;
    @(negedge clk);
    reseed = 1'b0;
    chk("reseed_zero", dut.r_lfsr, SEED);

    // Full drain with random spacing, including back-to-back requests
    for (int r = 1; r <= 13; r++) cnt[r] = 0;
    for (int i = 0; i < 52; i++) begin
      do_draw($urandom_range(0, 2), got, er);
      if (got >= 1 && got <= 13) cnt[got]++;
    end
    for (int r = 1; r <= 13; r++) chk("rank_count", cnt[r], 4);
    chk("drained", cards_left, 0);
    chk("lfsr_track", dut.r_lfsr, m_lfsr);

    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    chk("empty_err", empty_err, 1);
    chk("empty_novalid", card_valid, 0);
    chk("empty_idle", busy, 0);
    @(negedge clk);
    chk("empty_pulse", empty_err, 0);
    chk("empty_novalid2", card_valid, 0);
    chk("empty_idle2", busy, 0);

    // Shuffle and request together on an empty shoe
    shuffle = 1'b1; req = 1'b1;
    @(negedge clk);
    shuffle = 1'b0; req = 1'b0;
    fill_shoe();
    chk("sr_no_err", empty_err, 0);
    chk("sr_idle", busy, 0);
    chk("sr_left", cards_left, 52);
    do_draw(0, got, er);

    // Shuffle one cycle after a request aborts the draw
    do_draw(1, got, er);
    do_draw(0, got, er);
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0; shuffle = 1'b1;
    chk("abort_busy", busy, 1);
    @(negedge clk);
    shuffle = 1'b0;
    fill_shoe();
    chk("abort_idle", busy, 0);
    chk("abort_novalid", card_valid, 0);
    chk("abort_left", cards_left, 52);
    @(negedge clk);
    chk("abort_novalid2", card_valid, 0);

    // Same seed and same request timing give the same sequence
    s = 16'($urandom_range(1, 65535));
    for (int i = 0; i < 10; i++) gaps[i] = $urandom_range(0, 3);
    for (int run = 0; run < 2; run++) begin
      @(negedge clk);
      reseed = 1'b1; seed_in = s; shuffle = 1'b1;
      @(negedge clk);
      reseed = 1'b0; shuffle = 1'b0;
      fill_shoe();
      chk("reseed_load", dut.r_lfsr, s);
      for (int i = 0; i < 10; i++) begin
        do_draw(gaps[i], got, er);
        if (run == 0) exp1[i] = er;
        else          chk("repeat_seq", got, exp1[i]);
      end
    end

    // Asynchronous reset in the middle of a draw
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    chk("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", card_valid, 0);
    chk("arst_rank", card_rank, 0);
    chk("arst_empty", empty_err, 0);
    chk("arst_left", cards_left, 52);
    fill_shoe();
    @(negedge clk);
    rst_n = 1'b1;
    do_draw(0, got, er);
    chk("post_rst_range", (got >= 1 && got <= 13), 1);

    // Drain once more back-to-back so the sparse-shoe scan path is exercised again
    while (left > 0) do_draw(0, got, er);
    chk("drained2", cards_left, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
